// File: rtl/turn_referee.sv
`default_nettype none
// ============================================================================
// Module      : turn_referee
// Description : Two-player turn referee. It gates the per-turn timer, accepts
//               one move per turn over a valid/ack handshake, and keeps
//               saturating scores. A timer expiry forfeits the turn. After a
//               fixed number of rounds it declares a winner.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_referee #(
  parameter int MAX_ROUNDS = 5,
  parameter int SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               timer_done,
  output logic               timer_active,
  input  logic               p1_valid,
  input  logic               p1_point,
  input  logic               p2_valid,
  input  logic               p2_point,
  output logic               p1_ack,
  output logic               p2_ack,
  output logic               turn,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [7:0]         round,
  output logic               game_over,
  output logic [1:0]         winner
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TURN    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [7:0]         ROUND_LAST = 8'(MAX_ROUNDS);

  state_t             state, state_nx;
  logic               done_q;
  logic               timeout_evt;
  logic               move_valid;
  logic               move_point;
  logic               timer_active_nx;
  logic               p1_ack_nx, p2_ack_nx;
  logic               turn_nx;
  logic [SCORE_W-1:0] p1_score_nx, p2_score_nx;
  logic [7:0]         round_nx;
  logic               game_over_nx;
  logic [1:0]         winner_nx;

  // Only a fresh rising edge of the timer flag counts as an expiry, so a
  // level left high from the previous turn cannot forfeit the next one.
  assign timeout_evt = timer_done & ~done_q;

  // The move request that matters is the one from the player whose turn it is.
  assign move_valid = turn ? p2_valid : p1_valid;
  assign move_point = turn ? p2_point : p1_point;

  // State and every output are registered here; done_q tracks the timer flag
  // in all states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      done_q       <= 1'b0;
      timer_active <= 1'b0;
      p1_ack       <= 1'b0;
      p2_ack       <= 1'b0;
      turn         <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      round        <= 8'd0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
    end else begin
      state        <= state_nx;
      done_q       <= timer_done;
      timer_active <= timer_active_nx;
      p1_ack       <= p1_ack_nx;
      p2_ack       <= p2_ack_nx;
      turn         <= turn_nx;
      p1_score     <= p1_score_nx;
      p2_score     <= p2_score_nx;
      round        <= round_nx;
      game_over    <= game_over_nx;
      winner       <= winner_nx;
    end
  end

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_nx     = state;
    p1_ack_nx    = 1'b0;
    p2_ack_nx    = 1'b0;
    turn_nx      = turn;
    p1_score_nx  = p1_score;
    p2_score_nx  = p2_score;
    round_nx     = round;
    game_over_nx = game_over;
    winner_nx    = winner;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx     = ST_TURN;
          turn_nx      = 1'b0;
          p1_score_nx  = '0;
          p2_score_nx  = '0;
          round_nx     = 8'd0;
          game_over_nx = 1'b0;
          winner_nx    = 2'b00;
        end
      end

      ST_TURN: begin
        // A move in the same cycle as an expiry edge takes priority.
        if (move_valid) begin
          state_nx = ST_RESOLVE;
          if (turn) begin
            p2_ack_nx = 1'b1;
            if (move_point && (p2_score != SCORE_MAX)) begin
              p2_score_nx = p2_score + 1'b1;
            end
          end else begin
            p1_ack_nx = 1'b1;
            if (move_point && (p1_score != SCORE_MAX)) begin
              p1_score_nx = p1_score + 1'b1;
            end
          end
        end else if (timeout_evt) begin
          state_nx = ST_RESOLVE;
        end
      end

      ST_RESOLVE: begin
        turn_nx = ~turn;
        if (turn) begin
          round_nx = round + 8'd1;
          if ((round + 8'd1) == ROUND_LAST) begin
            state_nx     = ST_DONE;
            game_over_nx = 1'b1;
            if (p1_score > p2_score) begin
              winner_nx = 2'b01;
            end else if (p2_score > p1_score) begin
              winner_nx = 2'b10;
            end else begin
              winner_nx = 2'b11;
            end
          end else begin
            state_nx = ST_TURN;
          end
        end else begin
          state_nx = ST_TURN;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    timer_active_nx = (state_nx == ST_TURN);
  end

endmodule
`default_nettype wire

// File: tb/tb_turn_referee.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_referee
// Description : Randomized scoreboard bench for turn_referee. A driver plays
//               whole games turn by turn and queues the outcome of each turn
//               from a score/round model; a monitor compares each turn end.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_referee;

  localparam int MAX_ROUNDS = 6;
  localparam int SCORE_W    = 2;
  localparam int SMAX       = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               timer_done = 1'b0;
  logic               timer_active;
  logic               p1_valid = 1'b0;
  logic               p1_point = 1'b0;
  logic               p2_valid = 1'b0;
  logic               p2_point = 1'b0;
  logic               p1_ack, p2_ack, turn;
  logic [SCORE_W-1:0] p1_score, p2_score;
  logic [7:0]         round;
  logic               game_over;
  logic [1:0]         winner;

  turn_referee #(.MAX_ROUNDS(MAX_ROUNDS), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .timer_done(timer_done),
    .timer_active(timer_active), .p1_valid(p1_valid), .p1_point(p1_point),
    .p2_valid(p2_valid), .p2_point(p2_point), .p1_ack(p1_ack), .p2_ack(p2_ack),
    .turn(turn), .p1_score(p1_score), .p2_score(p2_score), .round(round),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Expected outcome of one turn: values during the resolve cycle, then the
  // values one cycle later.
  typedef struct {
    int a1, a2, s1, s2, rnd;
    int go, turn_n, round_n, win;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   resetting = 1'b1;
  bit   prev_ta = 1'b0;
  bit   pend = 1'b0;
  exp_t pe;
  int   hold_cnt = 0;
  int   ms1 = 0, ms2 = 0, mrnd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a turn ends when timer_active falls outside reset.
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      chk("next_game_over", game_over, pe.go);
      chk("next_round", round, pe.round_n);
      chk("next_timer_active", timer_active, pe.go ? 0 : 1);
      if (pe.go != 0) chk("winner", winner, pe.win);
      else            chk("next_turn", turn, pe.turn_n);
    end
    if (!resetting && prev_ta && !timer_active) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_turn_end: got turn end expected none at %0t", $time);
      end else begin
        pe = q.pop_front();
        chk("p1_ack", p1_ack, pe.a1);
        chk("p2_ack", p2_ack, pe.a2);
        chk("p1_score", p1_score, pe.s1);
        chk("p2_score", p2_score, pe.s2);
        chk("round_at_resolve", round, pe.rnd);
        pend = 1'b1;
      end
    end else if (!resetting) begin
      chk("stray_p1_ack", p1_ack, 0);
      chk("stray_p2_ack", p2_ack, 0);
    end
    prev_ta = timer_active;
  end

  task automatic wait_turn();
    int b = 0;
    while (timer_active !== 1'b1 && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("turn_started", timer_active, 1);
  endtask

  // mode: 0 move, 1 timeout, 2 move and expiry edge in the same cycle
  task automatic play_turn(input int who, input int kind, input int fmode, input int fdelay);
    exp_t e;
    int   mode, d, pt, stray, r;
    bit   mv;
    wait_turn();
    chk("turn_at_start", turn, who);
    stray = ($urandom % 3 == 0) ? 1 : 0;
    if (stray != 0) begin
      if (who == 0) begin p2_valid = 1'b1; p2_point = 1'($urandom % 2); end
      else          begin p1_valid = 1'b1; p1_point = 1'($urandom % 2); end
    end
    if (timer_done) begin
      repeat (hold_cnt) @(negedge clk);
      timer_done = 1'b0;
    end
    r = $urandom % 10;
    mode = (r < 5) ? 0 : (r < 8) ? 1 : 2;
    if (kind != 0) mode = 0;
    if (fmode >= 0) mode = fmode;
    d = (fdelay >= 0) ? fdelay : $urandom_range(0, 6);
    if (mode != 0) d = d + 1;
    repeat (d) @(negedge clk);

    pt = (kind == 1) ? ((who == 0) ? 1 : 0) : (kind == 2) ? 1 : int'($urandom % 2);
    mv = (mode != 1);
    if (mv && pt != 0) begin
      if (who == 0) ms1 = (ms1 < SMAX) ? ms1 + 1 : ms1;
      else          ms2 = (ms2 < SMAX) ? ms2 + 1 : ms2;
    end
    e.a1 = (mv && who == 0) ? 1 : 0;
    e.a2 = (mv && who == 1) ? 1 : 0;
    e.s1 = ms1;
    e.s2 = ms2;
    e.rnd = mrnd;
    if (who == 1) mrnd++;
    e.go = (mrnd == MAX_ROUNDS) ? 1 : 0;
    e.round_n = mrnd;
    e.turn_n = (who == 0) ? 1 : 0;
    e.win = (ms1 > ms2) ? 1 : (ms2 > ms1) ? 2 : 3;
    q.push_back(e);

    p1_valid = 1'b0;
    p2_valid = 1'b0;
    if (mv) begin
      if (who == 0) begin p1_valid = 1'b1; p1_point = 1'(pt); end
      else          begin p2_valid = 1'b1; p2_point = 1'(pt); end
    end
    if (mode != 0) timer_done = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    if (timer_done) begin
      if ($urandom % 2 == 0) hold_cnt = $urandom_range(1, 4);
      else timer_done = 1'b0;
    end
  endtask

  task automatic do_reset();
    wait_turn();
    @(negedge clk);
    resetting = 1'b1;
    rst_n = 1'b0;
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    timer_done = 1'b0;
    @(negedge clk);
    chk("rst_timer_active", timer_active, 0);
    chk("rst_acks", {p1_ack, p2_ack}, 0);
    chk("rst_turn", turn, 0);
    chk("rst_p1_score", p1_score, 0);
    chk("rst_p2_score", p2_score, 0);
    chk("rst_round", round, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_queue_empty", q.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_timer_active", timer_active, 0);
    chk("idle_game_over", game_over, 0);
    resetting = 1'b0;
  endtask

  // kind: 0 random points, 1 only P1 scores, 2 both always score
  task automatic play_game(input int kind, input int fmode, input int fdelay, input int reset_at);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_timer_active", timer_active, 1);
    chk("start_turn", turn, 0);
    chk("start_p1_score", p1_score, 0);
    chk("start_p2_score", p2_score, 0);
    chk("start_round", round, 0);
    chk("start_game_over", game_over, 0);
    chk("start_winner", winner, 0);
    ms1 = 0;
    ms2 = 0;
    mrnd = 0;
    for (int t = 0; t < 2 * MAX_ROUNDS; t++) begin
      if (t == reset_at) begin
        do_reset();
        return;
      end
      play_turn(t % 2, kind, (t == 0) ? fmode : -1, (t == 0) ? fdelay : -1);
    end
    repeat (2) @(negedge clk);
    chk("game_over_held", game_over, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("init_timer_active", timer_active, 0);
    chk("init_acks", {p1_ack, p2_ack}, 0);
    chk("init_scores", {p1_score, p2_score}, 0);
    chk("init_round", round, 0);
    chk("init_game_over", game_over, 0);
    chk("init_winner", winner, 0);
    rst_n = 1'b1;
    @(negedge clk);
    resetting = 1'b0;

    play_game(0, 1, 550, -1);
    play_game(1, -1, -1, -1);
    play_game(2, -1, -1, -1);
    play_game(0, -1, -1, 3);
    for (int g = 0; g < 5; g++) play_game(0, -1, -1, -1);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
